// File: rtl/axi4_single_master.sv
// axi4_single_master
//
// Bridges a simple request/response memory port (LSU/IFU side) onto an AXI4
// bus as single-beat read or write transactions. At most one transaction is
// in flight; a request is accepted only when the master is idle, and a new
// request cannot be taken until the previous response has been consumed.
//
// Handshake semantics (all channels, request and response ports alike):
//   a transfer happens on the rising clk_i edge where valid and ready are
//   both high. Once raised, valid and its payload stay stable until that
//   edge. Ready never depends on valid from the same side.
//
// Optional build macro:
//   AXI_MASTER_TIMEOUT_EN - adds a 16-bit watchdog. If a transaction has not
//   completed TIMEOUT_CYCLES cycles after it started on the bus, every AXI
//   valid/ready output is dropped and an error response (rdata = 0) is
//   returned. Late slave responses are then ignored. Without the macro the
//   master waits indefinitely.
//
// Parameters:
//   ID             - AXI ID driven on arid/awid/wid and expected on rid/bid.
//   TIMEOUT_CYCLES - watchdog limit (only used with AXI_MASTER_TIMEOUT_EN),
//                    minimum 2, values above 65536 are not representable.
//
// Ports:
//   clk_i, rst_i             - clock (rising edge), synchronous active-high reset
//   req_*                    - request port: valid/ready, we, addr, wdata,
//                              wstrb, size (AXI size code 0..2)
//   rsp_*                    - response port: valid/ready, rdata (0 for
//                              writes), err
//   ar*/r*/aw*/w*/b*         - AXI4 master channels, single beat, INCR burst
//   dbg_state_o              - current FSM state, for checkers and debug

module axi4_single_master #(
  parameter logic [3:0]  ID             = 4'd0,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  // request / response port
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [3:0]  req_wstrb_i,
  input  logic [2:0]  req_size_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  // AR channel
  output logic [3:0]  arid_o,
  output logic [31:0] araddr_o,
  output logic [7:0]  arlen_o,
  output logic [2:0]  arsize_o,
  output logic [1:0]  arburst_o,
  output logic        arvalid_o,
  input  logic        arready_i,
  // R channel
  input  logic [3:0]  rid_i,
  input  logic [31:0] rdata_i,
  input  logic [1:0]  rresp_i,
  input  logic        rlast_i,
  input  logic        rvalid_i,
  output logic        rready_o,
  // AW channel
  output logic [3:0]  awid_o,
  output logic [31:0] awaddr_o,
  output logic [7:0]  awlen_o,
  output logic [2:0]  awsize_o,
  output logic [1:0]  awburst_o,
  output logic        awvalid_o,
  input  logic        awready_i,
  // W channel
  output logic [3:0]  wid_o,
  output logic [31:0] wdata_o,
  output logic [3:0]  wstrb_o,
  output logic        wlast_o,
  output logic        wvalid_o,
  input  logic        wready_i,
  // B channel
  input  logic [3:0]  bid_i,
  input  logic [1:0]  bresp_i,
  input  logic        bvalid_i,
  output logic        bready_o,
  // debug
  output logic [2:0]  dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_AR   = 3'd1,
    S_R    = 3'd2,
    S_WR   = 3'd3,
    S_B    = 3'd4,
    S_RSP  = 3'd5
  } state_t;

  state_t      state_q, state_d;

  // latched request
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic [2:0]  size_q;

  // per-channel completion flags for the write address/data phase
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;

  // response registers, held stable through RSP
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        aw_hs, w_hs;
  logic        timeout;

  // A TIMEOUT_CYCLES below 2 cannot work; this block only exists when the
  // value is out of range so the mistake shows up in the elaborated hierarchy.
  if (TIMEOUT_CYCLES < 2) begin : g_timeout_cycles_out_of_range
  end

  // ---------------------------------------------------------------------------
  // Optional watchdog
  // ---------------------------------------------------------------------------
`ifdef AXI_MASTER_TIMEOUT_EN
  localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] to_cnt_q;
  logic        busy;

  assign busy = (state_q == S_AR) || (state_q == S_R) ||
                (state_q == S_WR) || (state_q == S_B);

  // The budget covers the whole bus transaction (address + response phase),
  // so the count continues from AR into R and from WR into B. Using >=
  // keeps the limit effective even if a phase change lands on the limit.
  assign timeout = busy && (to_cnt_q >= TO_LIMIT);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      to_cnt_q <= 16'd0;
    end else if ((state_q == S_IDLE) && (state_d != S_IDLE)) begin
      to_cnt_q <= 16'd0;
    end else if (busy) begin
      to_cnt_q <= to_cnt_q + 16'd1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      rdata_q   <= 32'd0;
      err_q     <= 1'b0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      wstrb_q   <= 4'd0;
      size_q    <= 3'd0;
    end else begin
      state_q   <= state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      if ((state_q == S_IDLE) && req_valid_i) begin
        addr_q  <= req_addr_i;
        wdata_q <= req_wdata_i;
        wstrb_q <= req_wstrb_i;
        size_q  <= req_size_i;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  assign aw_hs = (state_q == S_WR) && !aw_done_q && awready_i;
  assign w_hs  = (state_q == S_WR) && !w_done_q  && wready_i;

  always_comb begin
    state_d   = state_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    rdata_d   = rdata_q;
    err_d     = err_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          state_d   = req_we_i ? S_WR : S_AR;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end

      S_AR: begin
        if (arready_i) begin
          state_d = S_R;
        end else if (timeout) begin
          state_d = S_RSP;
          rdata_d = 32'd0;
          err_d   = 1'b1;
        end
      end

      S_R: begin
        if (rvalid_i) begin
          state_d = S_RSP;
          rdata_d = rdata_i;
          err_d   = (rresp_i != 2'b00) || !rlast_i || (rid_i != ID);
        end else if (timeout) begin
          state_d = S_RSP;
          rdata_d = 32'd0;
          err_d   = 1'b1;
        end
      end

      S_WR: begin
        // AW and W complete independently; the phase ends once both have,
        // whether together or in either order.
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
          state_d   = S_B;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end else if (timeout) begin
          state_d   = S_RSP;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          rdata_d   = 32'd0;
          err_d     = 1'b1;
        end else begin
          aw_done_d = aw_done_q || aw_hs;
          w_done_d  = w_done_q  || w_hs;
        end
      end

      S_B: begin
        if (bvalid_i) begin
          state_d = S_RSP;
          rdata_d = 32'd0;
          err_d   = (bresp_i != 2'b00) || (bid_i != ID);
        end else if (timeout) begin
          state_d = S_RSP;
          rdata_d = 32'd0;
          err_d   = 1'b1;
        end
      end

      S_RSP: begin
        if (rsp_ready_i) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs: all handshake signals decode from registered state only
  // ---------------------------------------------------------------------------
  assign req_ready_o = (state_q == S_IDLE);
  assign rsp_valid_o = (state_q == S_RSP);
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;

  assign arid_o      = ID;
  assign araddr_o    = addr_q;
  assign arlen_o     = 8'd0;
  assign arsize_o    = size_q;
  assign arburst_o   = 2'b01;
  assign arvalid_o   = (state_q == S_AR);

  assign rready_o    = (state_q == S_R);

  assign awid_o      = ID;
  assign awaddr_o    = addr_q;
  assign awlen_o     = 8'd0;
  assign awsize_o    = size_q;
  assign awburst_o   = 2'b01;
  assign awvalid_o   = (state_q == S_WR) && !aw_done_q;

  assign wid_o       = ID;
  assign wdata_o     = wdata_q;
  assign wstrb_o     = wstrb_q;
  assign wlast_o     = 1'b1;
  assign wvalid_o    = (state_q == S_WR) && !w_done_q;

  assign bready_o    = (state_q == S_B);

  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_axi4_single_master.sv
// tb_axi4_single_master
//
// Self-checking bench for axi4_single_master. The bench plays both the
// requester and the AXI slave. Each transaction is described by its request
// and by how the slave behaves (ready/response delays, response fields);
// the expected response and latency follow directly from those choices and
// are queued in a scoreboard. Optional watchdog coverage is compiled in when
// AXI_MASTER_TIMEOUT_EN is defined (TIMEOUT_CYCLES = 8 here).

module tb_axi4_single_master;

  localparam logic [3:0]  ID      = 4'd0;
  localparam int unsigned TIMEOUT = 8;
  localparam int          BUDGET  = 100;

  logic        clk_i;
  logic        rst_i;
  logic        req_valid_i, req_ready_o, req_we_i;
  logic [31:0] req_addr_i, req_wdata_i;
  logic [3:0]  req_wstrb_i;
  logic [2:0]  req_size_i;
  logic        rsp_valid_o, rsp_ready_i, rsp_err_o;
  logic [31:0] rsp_rdata_o;
  logic [3:0]  arid_o, awid_o, wid_o, rid_i, bid_i;
  logic [31:0] araddr_o, awaddr_o, wdata_o, rdata_i;
  logic [7:0]  arlen_o, awlen_o;
  logic [2:0]  arsize_o, awsize_o, dbg_state_o;
  logic [1:0]  arburst_o, awburst_o, rresp_i, bresp_i;
  logic        arvalid_o, arready_i, rlast_i, rvalid_i, rready_o;
  logic        awvalid_o, awready_i, wlast_o, wvalid_o, wready_i;
  logic [3:0]  wstrb_o;
  logic        bvalid_i, bready_o;

  int          n_vec = 0;
  int          n_err = 0;
  logic [32:0] exp_q[$];   // {err, rdata}

  // ---------------------------------------------------------------- clock/reset
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  axi4_single_master #(.ID(ID), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_wstrb_i(req_wstrb_i),
    .req_size_i(req_size_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
    .rsp_err_o(rsp_err_o),
    .arid_o(arid_o), .araddr_o(araddr_o), .arlen_o(arlen_o), .arsize_o(arsize_o),
    .arburst_o(arburst_o), .arvalid_o(arvalid_o), .arready_i(arready_i),
    .rid_i(rid_i), .rdata_i(rdata_i), .rresp_i(rresp_i), .rlast_i(rlast_i),
    .rvalid_i(rvalid_i), .rready_o(rready_o),
    .awid_o(awid_o), .awaddr_o(awaddr_o), .awlen_o(awlen_o), .awsize_o(awsize_o),
    .awburst_o(awburst_o), .awvalid_o(awvalid_o), .awready_i(awready_i),
    .wid_o(wid_o), .wdata_o(wdata_o), .wstrb_o(wstrb_o), .wlast_o(wlast_o),
    .wvalid_o(wvalid_o), .wready_i(wready_i),
    .bid_i(bid_i), .bresp_i(bresp_i), .bvalid_i(bvalid_i), .bready_o(bready_o),
    .dbg_state_o(dbg_state_o)
  );

  // ---------------------------------------------------------------- checking
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- drivers
  task automatic idle_slave();
    arready_i = 1'b0; awready_i = 1'b0; wready_i = 1'b0;
    rvalid_i  = 1'b0; bvalid_i  = 1'b0;
    rid_i = 4'd0; rdata_i = 32'd0; rresp_i = 2'd0; rlast_i = 1'b0;
    bid_i = 4'd0; bresp_i = 2'd0;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    req_valid_i = 1'b0; req_we_i = 1'b0; req_addr_i = 32'd0; req_wdata_i = 32'd0;
    req_wstrb_i = 4'd0; req_size_i = 3'd0; rsp_ready_i = 1'b0;
    idle_slave();
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
  endtask

  // One complete transaction. s_dly is the delay of the slave's response
  // beat (R or B) after the address/data phase ends.
  task automatic run_txn(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input logic [2:0] size,
                         input int a_dly, input int w_dly, input int s_dly,
                         input logic [3:0] sid, input logic [1:0] resp, input bit last,
                         input logic [31:0] sdata, input int rsp_dly);
    logic [32:0] exp;
    int cyc, a_cnt, w_cnt, s_cnt, exp_lat;
    bit a_seen, w_seen, resp_phase;

    // reference: response and latency straight from the slave behaviour
    if (we) begin
      exp     = {(resp != 2'd0) || (sid != ID), 32'd0};
      exp_lat = 3 + ((a_dly > w_dly) ? a_dly : w_dly) + s_dly;
    end else begin
      exp     = {(resp != 2'd0) || !last || (sid != ID), sdata};
      exp_lat = 3 + a_dly + s_dly;
    end
    exp_q.push_back(exp);

    chk("req_ready_idle", {31'd0, req_ready_o}, 32'd1);
    req_valid_i = 1'b1; req_we_i = we; req_addr_i = addr; req_wdata_i = wdata;
    req_wstrb_i = wstrb; req_size_i = size;
    @(posedge clk_i); #1;
    // scramble the request bus: the master must use its latched copy
    req_valid_i = 1'b0; req_addr_i = $urandom; req_wdata_i = $urandom;
    req_wstrb_i = 4'($urandom); req_size_i = 3'($urandom);

    cyc = 1; a_cnt = 0; w_cnt = 0; s_cnt = 0; a_seen = 1'b0; w_seen = 1'b0;
    while (!rsp_valid_o && cyc < BUDGET) begin
      idle_slave();
      if (!we) begin
        resp_phase = a_seen;
        chk("arvalid", {31'd0, arvalid_o}, {31'd0, !a_seen});
        chk("rready", {31'd0, rready_o}, {31'd0, resp_phase});
        chk("bready_rd", {31'd0, bready_o}, 32'd0);
        if (!a_seen) begin
          chk("araddr", araddr_o, addr);
          chk("ar_fields", {arid_o, arlen_o, arsize_o, arburst_o},
              {ID, 8'd0, size, 2'b01});
          arready_i = (a_cnt == a_dly);
        end
        if (resp_phase && s_cnt == s_dly) begin
          rvalid_i = 1'b1; rid_i = sid; rdata_i = sdata; rresp_i = resp; rlast_i = last;
        end
        // a stray write response must be ignored
        bvalid_i = 1'($urandom_range(0, 1)); bresp_i = 2'd3;
      end else begin
        resp_phase = a_seen && w_seen;
        chk("awvalid", {31'd0, awvalid_o}, {31'd0, !a_seen});
        chk("wvalid", {31'd0, wvalid_o}, {31'd0, !w_seen});
        chk("bready", {31'd0, bready_o}, {31'd0, resp_phase});
        chk("rready_wr", {31'd0, rready_o}, 32'd0);
        if (!a_seen) begin
          chk("awaddr", awaddr_o, addr);
          chk("aw_fields", {awid_o, awlen_o, awsize_o, awburst_o},
              {ID, 8'd0, size, 2'b01});
          awready_i = (a_cnt == a_dly);
        end
        if (!w_seen) begin
          chk("wdata", wdata_o, wdata);
          chk("w_fields", {wid_o, wstrb_o, wlast_o}, {ID, wstrb, 1'b1});
          wready_i = (w_cnt == w_dly);
        end
        if (resp_phase && s_cnt == s_dly) begin
          bvalid_i = 1'b1; bid_i = sid; bresp_i = resp;
        end
        // a stray read beat must be ignored
        rvalid_i = 1'($urandom_range(0, 1)); rdata_i = 32'hBAD0_BAD0;
      end
      @(posedge clk_i); #1;
      if (!we) begin
        if (arready_i) a_seen = 1'b1; else if (!a_seen) a_cnt++;
      end else begin
        if (awready_i) a_seen = 1'b1; else if (!a_seen) a_cnt++;
        if (wready_i)  w_seen = 1'b1; else if (!w_seen) w_cnt++;
      end
      if (resp_phase) s_cnt++;
      cyc++;
    end
    idle_slave();
    chk("latency", cyc, exp_lat);

    // response held: must stay stable and block new requests
    for (int k = 0; k < rsp_dly; k++) begin
      req_valid_i = 1'b1; req_we_i = 1'($urandom);
      chk("rsp_hold_valid", {31'd0, rsp_valid_o}, 32'd1);
      chk("rsp_hold_ready", {31'd0, req_ready_o}, 32'd0);
      chk("rsp_hold_rdata", rsp_rdata_o, exp[31:0]);
      chk("rsp_hold_err", {31'd0, rsp_err_o}, {31'd0, exp[32]});
      @(posedge clk_i); #1;
    end
    req_valid_i = 1'b0;
    exp = exp_q.pop_front();
    rsp_ready_i = 1'b1;
    chk("rsp_valid", {31'd0, rsp_valid_o}, 32'd1);
    chk("rsp_rdata", rsp_rdata_o, exp[31:0]);
    chk("rsp_err", {31'd0, rsp_err_o}, {31'd0, exp[32]});
    @(posedge clk_i); #1;
    rsp_ready_i = 1'b0;
    chk("rsp_done", {31'd0, rsp_valid_o}, 32'd0);
  endtask

  // Enter B on a write, then reset: the transaction is abandoned.
  task automatic reset_in_b();
    req_valid_i = 1'b1; req_we_i = 1'b1; req_addr_i = 32'h1000_0000;
    req_wdata_i = 32'h1234_5678; req_wstrb_i = 4'hF; req_size_i = 3'd2;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    awready_i = 1'b1; wready_i = 1'b1;
    @(posedge clk_i); #1;
    idle_slave();
    chk("rst_b_bready", {31'd0, bready_o}, 32'd1);
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    chk("rst_b_bready_low", {31'd0, bready_o}, 32'd0);
    chk("rst_b_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
    chk("rst_b_req_ready", {31'd0, req_ready_o}, 32'd1);
    chk("rst_b_rsp_err", {31'd0, rsp_err_o}, 32'd0);
  endtask

`ifdef AXI_MASTER_TIMEOUT_EN
  task automatic timeout_read();
    int n;
    req_valid_i = 1'b1; req_we_i = 1'b0; req_addr_i = 32'h8000_0040; req_size_i = 3'd2;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    n = 0;
    while (arvalid_o && n < BUDGET) begin
      n++;
      @(posedge clk_i); #1;
    end
    chk("to_ar_cycles", n, TIMEOUT);
    chk("to_rsp_valid", {31'd0, rsp_valid_o}, 32'd1);
    chk("to_rsp_err", {31'd0, rsp_err_o}, 32'd1);
    chk("to_rsp_rdata", rsp_rdata_o, 32'd0);
    // a late read beat is ignored
    rvalid_i = 1'b1; rdata_i = 32'h5555_AAAA; rlast_i = 1'b1;
    chk("to_rready", {31'd0, rready_o}, 32'd0);
    @(posedge clk_i); #1;
    idle_slave();
    chk("to_rdata_stable", rsp_rdata_o, 32'd0);
    rsp_ready_i = 1'b1;
    @(posedge clk_i); #1;
    rsp_ready_i = 1'b0;
    chk("to_back_idle", {31'd0, req_ready_o}, 32'd1);
  endtask
`endif

  // ---------------------------------------------------------------- main
  initial begin
    do_reset();
    chk("reset_req_ready", {31'd0, req_ready_o}, 32'd1);
    chk("reset_valids", {26'd0, arvalid_o, rready_o, awvalid_o, wvalid_o, bready_o, rsp_valid_o},
        32'd0);
    chk("reset_rdata", rsp_rdata_o, 32'd0);
    chk("reset_err", {31'd0, rsp_err_o}, 32'd0);

    // directed cases
    run_txn(1'b0, 32'h8000_0010, 32'd0, 4'h0, 3'd2, 0, 0, 0, ID, 2'b00, 1'b1,
            32'hDEAD_BEEF, 0);
    run_txn(1'b1, 32'hA000_03F8, 32'h41, 4'b0001, 3'd0, 3, 0, 0, ID, 2'b00, 1'b1,
            32'd0, 0);
    run_txn(1'b0, 32'h8000_0020, 32'd0, 4'h0, 3'd2, 1, 0, 2, ID, 2'b10, 1'b1,
            32'h0BAD_F00D, 0);
    run_txn(1'b0, 32'h8000_0024, 32'd0, 4'h0, 3'd1, 0, 0, 1, ID + 4'd1, 2'b00, 1'b1,
            32'h1111_2222, 1);
    run_txn(1'b0, 32'h8000_0028, 32'd0, 4'h0, 3'd2, 0, 0, 0, ID, 2'b00, 1'b0,
            32'h3333_4444, 0);
    run_txn(1'b1, 32'hA000_0000, 32'hCAFE_0001, 4'b1111, 3'd2, 0, 2, 1, ID, 2'b11, 1'b1,
            32'd0, 0);
    run_txn(1'b1, 32'hA000_0004, 32'hCAFE_0002, 4'b1100, 3'd1, 0, 0, 0, ID, 2'b00, 1'b1,
            32'd0, 5);
    run_txn(1'b0, 32'h8000_0030, 32'd0, 4'h0, 3'd2, 0, 0, 0, ID, 2'b00, 1'b1,
            32'h7777_8888, 5);

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      logic [3:0] sid;
      logic [1:0] resp;
      sid  = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : ID;
      resp = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      run_txn(1'($urandom), $urandom, $urandom, 4'($urandom), 3'($urandom_range(0, 2)),
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
              sid, resp, ($urandom_range(0, 7) != 0), $urandom, $urandom_range(0, 3));
    end

    reset_in_b();
    run_txn(1'b0, 32'h8000_0044, 32'd0, 4'h0, 3'd2, 0, 0, 0, ID, 2'b00, 1'b1,
            32'h0102_0304, 0);

`ifdef AXI_MASTER_TIMEOUT_EN
    timeout_read();
`endif

    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "bench watchdog expired");
  end

endmodule
